// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin write arbiter that lets NUM_REQ producers share the write port of one
// synchronous FIFO. Each cycle the stage can load, one valid producer is picked. The
// search starts at the rotating priority pointer. The winner's word is registered into a
// single-entry output stage that drives the FIFO write port. The stage holds its word
// while the FIFO is full, so no word is dropped.
//
// Optional feature: define ARB_STATS_EN to add per-requester 16-bit saturating
// accepted-word counters on port grant_cnt.
//
// Parameters:
//   NUM_REQ     number of requesters, legal range 2..16
//   DATA_WIDTH  word width, must match the downstream FIFO
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester word offered
//   req_data      flattened words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     one-hot or zero; word i accepted when req_valid[i] & req_ready[i]
//   fifo_full     full flag from the FIFO
//   fifo_wr_en    write strobe to the FIFO
//   fifo_data_in  write data to the FIFO
//   grant_id      index of the requester whose word sits in the output stage
//   grant_cnt     per-requester accepted-word counters (ARB_STATS_EN only)

module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  // Candidate index is one bit wider so rr_ptr + offset cannot overflow before the wrap.
  localparam int unsigned CAND_W = ID_W + 1;
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CAND_W-1:0] NUM_REQ_C = CAND_W'(NUM_REQ);

  // Output stage and arbitration state.
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [ID_W-1:0]       grant_id_q,  grant_id_d;
  logic [ID_W-1:0]       rr_ptr_q,    rr_ptr_d;

  // Arbitration results.
  logic                  load;
  logic                  win_found;
  logic [ID_W-1:0]       win_idx;
  logic [NUM_REQ-1:0]    win_oh;
  logic [DATA_WIDTH-1:0] win_data;
  logic [CAND_W-1:0]     cand;

  // The stage can take a word when it is empty or drains into the FIFO this cycle.
  assign load = ~out_valid_q | ~fifo_full;

  // Round-robin search: visit rr_ptr, rr_ptr+1, ... with explicit wrap, so that a
  // non-power-of-two NUM_REQ never selects an index past NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CAND_W'(k);
      if (cand >= NUM_REQ_C) begin
        cand = cand - NUM_REQ_C;
      end
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
    win_oh[win_idx] = win_found;
  end

  // AND-OR select of the winner's word; win_oh has at most one bit set.
  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_oh[k]) begin
        win_data = win_data | req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // req_ready is gated by rst_n so that no word is reported as taken while in reset.
  assign req_ready    = (rst_n && load) ? win_oh : '0;
  assign fifo_wr_en   = out_valid_q & ~fifo_full;
  assign fifo_data_in = out_data_q;
  assign grant_id     = grant_id_q;

  // Next-state logic. With no pending request the stage empties, but data, id and
  // pointer keep their last values.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = win_found;
      if (win_found) begin
        out_data_d = win_data;
        grant_id_d = win_idx;
        rr_ptr_d   = (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef ARB_STATS_EN
  // Per-requester accepted-word counters, saturating at all ones.
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (req_valid[k] && req_ready[k] && (cnt_q[k] != 16'hFFFF)) begin
          cnt_q[k] <= cnt_q[k] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      grant_cnt[k*16 +: 16] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic. A
// queue-level model of the arbiter is checked against the DUT on every falling edge.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [IW-1:0]   grant_id;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  bit            m_full;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_prio;
  int unsigned   m_cnt [N];
  int            wait_cnt [N];
  int            max_wait;
  int            grant_log [$];
  logic [DW-1:0] wr_log [$];

  bit            mdl_load;
  int            mdl_win;
  logic [N-1:0]  mdl_ready;

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_id   = 0;
    m_prio = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]    = 0;
      wait_cnt[i] = 0;
    end
  endtask

  initial begin
    max_wait = 0;
    model_reset();
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        #1;
        check("reset fifo_wr_en", fifo_wr_en, 0);
        check("reset req_ready", req_ready, 0);
        check("reset grant_id", grant_id, 0);
        check("reset fifo_data_in", fifo_data_in, 0);
      end else begin
        // Expected outputs for this cycle, from the arbitration rule.
        mdl_load = !m_full || !fifo_full;
        mdl_win  = -1;
        if (mdl_load) begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_prio + k) % N;
            if (mdl_win < 0 && req_valid[i]) mdl_win = i;
          end
        end
        mdl_ready = '0;
        if (mdl_win >= 0) mdl_ready[mdl_win] = 1'b1;
        check("req_ready", req_ready, mdl_ready);
        check("fifo_wr_en", fifo_wr_en, m_full && !fifo_full);
        check("fifo_data_in", fifo_data_in, m_data);
        check("grant_id", grant_id, m_id);
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
        if (m_full && !fifo_full) wr_log.push_back(m_data);
        // Fairness bookkeeping: acceptances seen by a valid but unserved requester.
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] || i == mdl_win) begin
            wait_cnt[i] = 0;
          end else if (mdl_win >= 0) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
          end
        end
        // State update for the coming rising edge.
        if (mdl_load) begin
          m_full = (mdl_win >= 0);
          if (mdl_win >= 0) begin
            m_data = req_data[mdl_win*DW +: DW];
            m_id   = mdl_win;
            m_prio = (mdl_win + 1) % N;
            grant_log.push_back(mdl_win);
            if (m_cnt[mdl_win] < 32'hFFFF) m_cnt[mdl_win]++;
          end
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // Starts and ends 1 time unit after a rising edge; returns what was accepted.
  task automatic cycle(output logic [N-1:0] acc);
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  int            exp_rr [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
  logic [N-1:0]  acc;
  logic [N-1:0]  one_hot;
  logic [DW-1:0] held;
  int            sent;
  int            acc_n;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random inputs.
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      req_valid = N'($urandom);
      fifo_full = 1'($urandom);
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      #1;
      check("rst rand fifo_wr_en", fifo_wr_en, 0);
      check("rst rand req_ready", req_ready, 0);
      check("rst rand grant_id", grant_id, 0);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    fifo_full = 1'b0;
    rst_n     = 1'b1;
    repeat (3) begin
      cycle(acc);
      check("idle fifo_wr_en", fifo_wr_en, 0);
    end

    // Round robin: 1111 for 8 accepts, then 1010 for 4.
    grant_log.delete();
    for (int i = 0; i < N; i++) set_data(i, $urandom);
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b1010;
      cycle(acc);
      one_hot = '0;
      one_hot[exp_rr[k]] = 1'b1;
      check("rr order", acc, one_hot);
    end
    check("rr grant_id", grant_id, 3);
    check("rr model log size", grant_log.size(), 12);
    req_valid = '0;
    cycle(acc);

    // Single stream from requester 2.
    wr_log.delete();
    req_valid = 4'b0100;
    set_data(2, 32'hA0);
    #1;
    check("ss first fifo_wr_en", fifo_wr_en, 0);
    for (int k = 0; k < 10; k++) begin
      set_data(2, 32'hA0 + k);
      cycle(acc);
      check("ss accept", acc, 4'b0100);
      check("ss fifo_wr_en", fifo_wr_en, 1);
      check("ss data", fifo_data_in, 32'hA0 + k);
      check("ss grant_id", grant_id, 2);
    end
    req_valid = '0;
    cycle(acc);
    check("ss drained", fifo_wr_en, 0);
    check("ss written count", wr_log.size(), 10);
    for (int k = 0; k < wr_log.size() && k < 10; k++) check("ss written", wr_log[k], 32'hA0 + k);

    // Backpressure on a stream from requester 0.
    wr_log.delete();
    sent = 0;
    held = '0;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      req_valid = 4'b0001;
      set_data(0, 32'hB0 + sent);
      fifo_full = (c >= 4 && c < 7);
      #1;
      if (c == 4) held = fifo_data_in;
      if (c >= 4 && c < 7) begin
        check("bp fifo_wr_en", fifo_wr_en, 0);
        check("bp req_ready", req_ready, 0);
        check("bp data stable", fifo_data_in, held);
      end
      cycle(acc);
      if (acc[0]) sent++;
    end
    fifo_full = 1'b0;
    req_valid = '0;
    cycle(acc);
    cycle(acc);
    check("bp held word", held, 32'hB3);
    check("bp written count", wr_log.size(), 10);
    for (int k = 0; k < wr_log.size() && k < 10; k++) check("bp written", wr_log[k], 32'hB0 + k);

    // Reset while the stage is full and the FIFO is full.
    req_valid = 4'b0001;
    set_data(0, 32'hC0);
    cycle(acc);
    req_valid = '0;
    fifo_full = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst fifo_wr_en", fifo_wr_en, 0);
    check("mrst data", fifo_data_in, 0);
    fifo_full = 1'b0;
    #1;
    check("mrst stage discarded", fifo_wr_en, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    cycle(acc);
    check("mrst first grant", acc, 4'b0001);
    req_valid = '0;
    cycle(acc);

    // Randomized traffic with well-behaved producers.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
          req_valid[i] = 1'b1;
          set_data(i, $urandom);
        end
      end
      fifo_full = ($urandom_range(0, 99) < 30);
      cycle(acc);
      req_valid = req_valid & ~acc;
    end
    req_valid = '0;
    fifo_full = 1'b0;
    cycle(acc);
    cycle(acc);
    check("fairness bound", max_wait <= N - 1, 1);

`ifdef ARB_STATS_EN
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b0010;
    fifo_full = 1'b0;
    acc_n = 0;
    for (int g = 0; g < 80000 && acc_n < 70000; g++) begin
      set_data(1, $urandom);
      cycle(acc);
      if (acc[1]) acc_n++;
    end
    check("stats accepts", acc_n, 70000);
    req_valid = '0;
    cycle(acc);
    check("stats cnt1 saturated", grant_cnt[16 +: 16], 16'hFFFF);
    check("stats cnt0", grant_cnt[0 +: 16], 0);
    check("stats cnt2", grant_cnt[32 +: 16], 0);
    check("stats cnt3", grant_cnt[48 +: 16], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
